// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the single RAM port to either the data-side request
// stream or the instruction-fetch stream, one transaction at a time.
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   iREN/iaddr           instruction read request; iload/iwait response
//   dREN/dWEN/daddr/dstore data request; dload/dwait response
//   ramREN/ramWEN/ramaddr/ramstore  RAM command, driven only while granted
//   ramload/ramstate     RAM response (FREE=0, BUSY=1, ACCESS=2, ERROR=3)
//   busErr               sticky error flag: RAM ERROR or watchdog timeout
//
// Optional feature: define MEMARB_FAIR_EN to give the instruction side one
// turn after every data-side completion (bounds fetch starvation).
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        busErr
);
    localparam logic [1:0]  RS_ACCESS = 2'd2;
    localparam logic [1:0]  RS_ERROR  = 2'd3;
    localparam logic [15:0] CNT_LAST  = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        busErr_q, busErr_d;
    logic        d_req, owner_req, granted, done_ok, done_err;
    logic [31:0] done_val;
`ifdef MEMARB_FAIR_EN
    logic        iPrio_q, iPrio_d;
`endif

    assign d_req  = dREN | dWEN;
    assign busErr = busErr_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busErr_q <= 1'b0;
`ifdef MEMARB_FAIR_EN
            iPrio_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busErr_q <= busErr_d;
`ifdef MEMARB_FAIR_EN
            iPrio_q  <= iPrio_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        busErr_d  = busErr_q;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        iload     = '0;
        dload     = '0;
        iwait     = iREN;
        dwait     = d_req;
        owner_req = 1'b0;
        granted   = 1'b0;
        done_ok   = 1'b0;
        done_err  = 1'b0;
        done_val  = '0;
`ifdef MEMARB_FAIR_EN
        iPrio_d   = iPrio_q;
`endif

        case (state_q)
            IDLE: begin
`ifdef MEMARB_FAIR_EN
                if (iPrio_q && iREN) state_d = IGRANT;
                else if (d_req)      state_d = DGRANT;
                else if (iREN)       state_d = IGRANT;
                if (state_d == IGRANT) iPrio_d = 1'b0;
`else
                if (d_req)     state_d = DGRANT;
                else if (iREN) state_d = IGRANT;
`endif
            end
            DGRANT: begin
                granted   = 1'b1;
                owner_req = d_req;
                // write wins when both enables are raised
                ramWEN    = dWEN;
                ramREN    = dREN & ~dWEN;
                ramaddr   = daddr;
                ramstore  = dstore;
            end
            IGRANT: begin
                granted   = 1'b1;
                owner_req = iREN;
                ramREN    = iREN;
                ramaddr   = iaddr;
            end
            default: state_d = IDLE;
        endcase

        if (granted) begin
            cnt_d = cnt_q + 16'd1;
            if (!owner_req) begin
                // owner withdrew: abort without a completion
                state_d = IDLE;
            end else if (ramstate == RS_ERROR ||
                         (ramstate != RS_ACCESS && cnt_q == CNT_LAST)) begin
                done_err = 1'b1;
            end else if (ramstate == RS_ACCESS) begin
                done_ok = 1'b1;
            end
        end

        if (done_ok || done_err) begin
            state_d = IDLE;
            if (done_err)                        done_val = ERR_DATA;
            else if (state_q == DGRANT && dWEN)  done_val = '0;
            else                                 done_val = ramload;
            if (done_err) busErr_d = 1'b1;
            if (state_q == DGRANT) begin
                dload = done_val;
                dwait = 1'b0;
`ifdef MEMARB_FAIR_EN
                iPrio_d = 1'b1;
`endif
            end else begin
                iload = done_val;
                iwait = 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int          TMO  = 8;
    localparam logic [31:0] ERRV = 32'hBAD1BAD1;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        iwait, dwait, ramREN, ramWEN, busErr;
    logic [31:0] ramload = '0;
    logic [1:0]  ramstate = 2'd0;

    mem_arbiter #(.TIMEOUT_CYCLES(TMO), .ERR_DATA(ERRV)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .busErr(busErr)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model: plain memory contents ----------------
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] ram_mem [logic [31:0]];
    logic [31:0] dq[$];
    logic [31:0] iq[$];
    bit          order_q[$];   // 1 = data completion, 0 = instruction

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0F0F1234;
    endfunction
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction
    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : init_val(a);
    endfunction

    // ---------------- RAM device model ----------------
    // mode 0: random 0..3 BUSY cycles, 1: fixed busy_fix, 2: hang BUSY, 3: ERROR
    int ram_mode = 0;
    int busy_fix = 0;
    int busy_left = 0;

    function automatic int next_busy();
        return (ram_mode == 1) ? busy_fix : int'($urandom_range(0, 3));
    endfunction

    always @(posedge CLK) begin
        #2;
        if (ramREN || ramWEN) begin
            if (ram_mode == 2) begin
                ramstate = 2'd1; ramload = $urandom;
            end else if (ram_mode == 3) begin
                ramstate = 2'd3; ramload = $urandom;
            end else if (busy_left > 0) begin
                ramstate = 2'd1; ramload = $urandom; busy_left--;
            end else begin
                ramstate = 2'd2;
                ramload  = ramREN ? ram_rd(ramaddr) : $urandom;
                if (ramWEN) ram_mem[ramaddr] = ramstore;
                busy_left = next_busy();
            end
        end else begin
            ramstate  = 2'd0;
            ramload   = $urandom;
            busy_left = next_busy();
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge CLK) begin
        if (nRST) begin
            if ((dREN || dWEN) && !dwait) begin
                order_q.push_back(1'b1);
                if (dq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL d_unexpected: got completion %h expected none", dload);
                end else chk("dload", dload, dq.pop_front());
            end else chk("dload_zero", dload, 32'h0);
            if (iREN && !iwait) begin
                order_q.push_back(1'b0);
                if (iq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL i_unexpected: got completion %h expected none", iload);
                end else chk("iload", iload, iq.pop_front());
            end else chk("iload_zero", iload, 32'h0);
        end
    end

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge CLK); #1;
    endtask

    task automatic d_issue(input bit wr, input bit rd, input logic [31:0] a,
                           input logic [31:0] d, input bit err);
        dWEN = wr; dREN = rd; daddr = a; dstore = d;
        if (err)     dq.push_back(ERRV);
        else if (wr) dq.push_back(32'h0);
        else         dq.push_back(ref_rd(a));
        if (wr && !err) ref_mem[a] = d;
    endtask

    task automatic i_issue(input logic [31:0] a, input bit err);
        iREN = 1'b1; iaddr = a;
        iq.push_back(err ? ERRV : ref_rd(a));
    endtask

    // lat = index of completion cycle (issue cycle is 0); ren_h[k] = ramREN in cycle k
    task automatic d_wait(output int lat, output logic [15:0] ren_h);
        lat = 0; ren_h = '0;
        forever begin
            @(negedge CLK);
            if (lat < 16) ren_h[lat] = ramREN;
            if (!dwait) break;
            lat++;
            if (lat > 200) begin
                tests++; fails++;
                $display("FAIL d_wait_bound: got no completion expected one within 200 cycles");
                break;
            end
        end
        step();
    endtask

    task automatic i_wait(output int lat);
        lat = 0;
        forever begin
            @(negedge CLK);
            if (!iwait) break;
            lat++;
            if (lat > 200) begin
                tests++; fails++;
                $display("FAIL i_wait_bound: got no completion expected one within 200 cycles");
                break;
            end
        end
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int lat_d, lat_i;
        logic [15:0] rh;
        logic [4:0]  pat, pat_exp;

        // reset state
        #3;
        chk("rst_ramREN", ramREN, 0);  chk("rst_ramWEN", ramWEN, 0);
        chk("rst_ramaddr", ramaddr, 0); chk("rst_ramstore", ramstore, 0);
        chk("rst_dload", dload, 0);    chk("rst_iload", iload, 0);
        chk("rst_busErr", busErr, 0);
        dREN = 1'b1; #1;
        chk("rst_dwait", dwait, 1);    chk("rst_iwait", iwait, 0);
        dREN = 1'b0;
        step(); step();
        nRST = 1'b1;
        step();

        // randomized traffic on both sides
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    int gap; int k; logic [31:0] a;
                    gap = $urandom_range(0, 2);
                    k   = $urandom_range(0, 2);
                    a   = 32'h100 + ($urandom_range(0, 15) << 2);
                    for (int g = 0; g < gap; g++) step();
                    d_issue(k != 0, k != 1, a, $urandom, 1'b0);
                    d_wait(lat_d, rh);
                    dREN = 1'b0; dWEN = 1'b0;
                end
            end
            begin
                int li; logic [15:0] unused_h;
                unused_h = '0;
                for (int n = 0; n < 30; n++) begin
                    int gap;
                    gap = $urandom_range(0, 3);
                    for (int g = 0; g < gap; g++) step();
                    i_issue(32'h1000 + ($urandom_range(0, 63) << 2), 1'b0);
                    i_wait(li);
                    iREN = 1'b0;
                end
            end
        join
        step();
        chk("rand_dq_drained", dq.size(), 0);
        chk("rand_iq_drained", iq.size(), 0);

        // data read, 2 BUSY then ACCESS
        ram_mode = 1; busy_fix = 2;
        ref_mem[32'h100] = 32'hCAFEF00D; ram_mem[32'h100] = 32'hCAFEF00D;
        step();
        d_issue(1'b0, 1'b1, 32'h100, 32'h0, 1'b0);
        d_wait(lat_d, rh);
        dREN = 1'b0;
        chk("t1_latency", lat_d, 3);
        chk("t1_ramREN_hist", rh, 16'h000E);

        // write wins over read
        busy_fix = 0; step();
        d_issue(1'b1, 1'b1, 32'h104, 32'h12345678, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        chk("ww_ramWEN", ramWEN, 1); chk("ww_ramREN", ramREN, 0);
        chk("ww_ramstore", ramstore, 32'h12345678); chk("ww_dwait", dwait, 0);
        step();
        dREN = 1'b0; dWEN = 1'b0;
        step();

        // simultaneous requests: data first, instruction two cycles later
        d_issue(1'b0, 1'b1, 32'h108, 32'h0, 1'b0);
        i_issue(32'h1004, 1'b0);
        fork
            begin d_wait(lat_d, rh); dREN = 1'b0; end
            begin i_wait(lat_i); iREN = 1'b0; end
        join
        chk("prio_d_lat", lat_d, 1);
        chk("prio_i_lat", lat_i, 3);

        // grant order under continuous data reads
        step();
        order_q.delete();
        fork
            begin
                for (int n = 0; n < 4; n++) begin
                    d_issue(1'b0, 1'b1, 32'h10C + (n << 2), 32'h0, 1'b0);
                    d_wait(lat_d, rh);
                end
                dREN = 1'b0;
            end
            begin i_issue(32'h1008, 1'b0); i_wait(lat_i); iREN = 1'b0; end
        join
        pat = '0;
        foreach (order_q[j]) pat = {pat[3:0], order_q[j]};
`ifdef MEMARB_FAIR_EN
        pat_exp = 5'b10111;
`else
        pat_exp = 5'b11110;
`endif
        chk("order_count", order_q.size(), 5);
        chk("order_pattern", pat, pat_exp);

        // watchdog timeout on a hung RAM
        step();
        chk("pre_to_busErr", busErr, 0);
        ram_mode = 2;
        d_issue(1'b0, 1'b1, 32'h120, 32'h0, 1'b1);
        d_wait(lat_d, rh);
        dREN = 1'b0;
        chk("to_latency", lat_d, TMO);
        chk("to_busErr", busErr, 1);

        // RAM ERROR on the instruction side; busErr stays set
        ram_mode = 3; step();
        i_issue(32'h100C, 1'b1);
        i_wait(lat_i);
        iREN = 1'b0;
        chk("err_i_latency", lat_i, 1);
        ram_mode = 0; step();
        d_issue(1'b0, 1'b1, 32'h124, 32'h0, 1'b0);
        d_wait(lat_d, rh);
        dREN = 1'b0;
        chk("sticky_busErr", busErr, 1);

        // reset mid-grant
        ram_mode = 2; step();
        dREN = 1'b1; daddr = 32'h128;
        @(negedge CLK);
        @(negedge CLK);
        chk("mid_ramREN_granted", ramREN, 1);
        #1 nRST = 1'b0;
        #1;
        chk("mid_rst_ramREN", ramREN, 0);
        chk("mid_rst_busErr", busErr, 0);
        chk("mid_rst_dwait", dwait, 1);
        dREN = 1'b0;
        step();
        nRST = 1'b1;
        ram_mode = 1; busy_fix = 0;
        i_issue(32'h1010, 1'b0);
        i_wait(lat_i);
        iREN = 1'b0;
        chk("post_rst_i_lat", lat_i, 1);

        step(); step();
        chk("end_dq_drained", dq.size(), 0);
        chk("end_iq_drained", iq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
